// File: rtl/spi_slave_model.sv
// SPI slave device model: samples an asynchronous SPI bus in the system clock domain,
// replies from a programmable response table and captures received words.
module spi_slave_model #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORDS      = 4,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic [31:0] INIT_WORD  = 32'hACDC1112
) (
    input  logic                     i_system_clk,
    input  logic                     i_reset_n,
    input  logic                     i_sck,
    input  logic                     i_cs,
    input  logic                     i_mosi,
    output logic                     o_miso,
    input  logic                     i_load_valid,
    input  logic [$clog2(WORDS)-1:0] i_load_addr,
    input  logic [DATA_WIDTH-1:0]    i_load_data,
    output logic [DATA_WIDTH-1:0]    o_rx_data,
    output logic                     o_rx_valid,
    output logic [$clog2(WORDS)-1:0] o_word_index,
    output logic                     o_frame_done,
    output logic                     o_frame_error,
    output logic                     o_busy
);
    localparam int unsigned           AW         = $clog2(WORDS);
    localparam int unsigned           CW         = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] INIT_C     = DATA_WIDTH'(INIT_WORD);
    localparam logic [CW-1:0]         LAST_BIT_C = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state_r, state_next_s;
    logic                    sck_meta_r, sck_sync_r, sck_hist_r;
    logic                    cs_meta_r, cs_sync_r, cs_hist_r;
    logic                    mosi_meta_r, mosi_sync_r;
    logic                    sck_edge_s, lead_s, trail_s, sample_s, shift_s;
    logic                    cs_fall_s, cs_rise_s;
    logic [DATA_WIDTH-1:0]   table_r [WORDS];
    logic [DATA_WIDTH-1:0]   tx_shift_r, rx_shift_r, rx_data_r;
    logic [DATA_WIDTH-1:0]   tx_next_s, rx_next_s;
    logic [CW-1:0]           bit_cnt_r;
    logic [AW-1:0]           word_idx_r;
    logic                    rx_valid_r, frame_done_r, frame_error_r;
    logic                    skip_shift_r, load_pending_r;
    logic                    miso_s;

    // Bus synchronisers; SCK and CS keep one extra history stage for edge detection
    always_ff @(posedge i_system_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sck_meta_r  <= CPOL;
            sck_sync_r  <= CPOL;
            sck_hist_r  <= CPOL;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_hist_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sck_meta_r  <= i_sck;
            sck_sync_r  <= sck_meta_r;
            sck_hist_r  <= sck_sync_r;
            cs_meta_r   <= i_cs;
            cs_sync_r   <= cs_meta_r;
            cs_hist_r   <= cs_sync_r;
            mosi_meta_r <= i_mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // Leading edge leaves the CPOL idle level, trailing edge returns to it
    assign sck_edge_s = sck_sync_r ^ sck_hist_r;
    assign lead_s     = sck_edge_s & (sck_sync_r ^ CPOL);
    assign trail_s    = sck_edge_s & ~(sck_sync_r ^ CPOL);
    assign sample_s   = CPHA ? trail_s : lead_s;
    assign shift_s    = CPHA ? lead_s : trail_s;
    assign cs_fall_s  = cs_hist_r & ~cs_sync_r;
    assign cs_rise_s  = ~cs_hist_r & cs_sync_r;

    // Shift-register next values in the configured bit order
    always_comb begin
        if (MSB_FIRST) begin
            rx_next_s = {rx_shift_r[DATA_WIDTH-2:0], mosi_sync_r};
            tx_next_s = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
            miso_s    = tx_shift_r[DATA_WIDTH-1];
        end else begin
            rx_next_s = {mosi_sync_r, rx_shift_r[DATA_WIDTH-1:1]};
            tx_next_s = {1'b0, tx_shift_r[DATA_WIDTH-1:1]};
            miso_s    = tx_shift_r[0];
        end
    end

    // Frame state register
    always_ff @(posedge i_system_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame state transitions on synchronised chip-select edges
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) state_next_s = ST_ACTIVE;
                else           state_next_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (cs_rise_s) state_next_s = ST_IDLE;
                else           state_next_s = ST_ACTIVE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Response table; a load in the same cycle as a write sees the old entry
    always_ff @(posedge i_system_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < WORDS; i++) table_r[i] <= INIT_C;
        end else if (i_load_valid) begin
            table_r[i_load_addr] <= i_load_data;
        end
    end

    // Shift datapath; CS edges win over any SCK edge seen in the same cycle
    always_ff @(posedge i_system_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_shift_r     <= {DATA_WIDTH{1'b0}};
            rx_shift_r     <= {DATA_WIDTH{1'b0}};
            rx_data_r      <= {DATA_WIDTH{1'b0}};
            bit_cnt_r      <= {CW{1'b0}};
            word_idx_r     <= {AW{1'b0}};
            rx_valid_r     <= 1'b0;
            frame_done_r   <= 1'b0;
            frame_error_r  <= 1'b0;
            skip_shift_r   <= 1'b0;
            load_pending_r <= 1'b0;
        end else begin
            rx_valid_r   <= 1'b0;
            frame_done_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                if (cs_fall_s) begin
                    tx_shift_r     <= table_r[AW'(0)];
                    bit_cnt_r      <= {CW{1'b0}};
                    word_idx_r     <= {AW{1'b0}};
                    frame_error_r  <= 1'b0;
                    skip_shift_r   <= CPHA;
                    load_pending_r <= 1'b0;
                end
            end else if (cs_rise_s) begin
                frame_done_r   <= 1'b1;
                if (bit_cnt_r != {CW{1'b0}}) frame_error_r <= 1'b1;
                bit_cnt_r      <= {CW{1'b0}};
                word_idx_r     <= {AW{1'b0}};
                skip_shift_r   <= 1'b0;
                load_pending_r <= 1'b0;
            end else begin
                if (sample_s) begin
                    rx_shift_r <= rx_next_s;
                    if (bit_cnt_r == LAST_BIT_C) begin
                        rx_data_r      <= rx_next_s;
                        rx_valid_r     <= 1'b1;
                        bit_cnt_r      <= {CW{1'b0}};
                        word_idx_r     <= word_idx_r + AW'(1);
                        load_pending_r <= 1'b1;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                // CPHA=1 first leading edge only arms sampling; word boundaries reload
                if (shift_s) begin
                    if (skip_shift_r) begin
                        skip_shift_r <= 1'b0;
                    end else if (load_pending_r) begin
                        tx_shift_r     <= table_r[word_idx_r];
                        load_pending_r <= 1'b0;
                    end else begin
                        tx_shift_r <= tx_next_s;
                    end
                end
            end
        end
    end

    assign o_miso        = i_cs ? 1'bz : miso_s;
    assign o_rx_data     = rx_data_r;
    assign o_rx_valid    = rx_valid_r;
    assign o_word_index  = word_idx_r;
    assign o_frame_done  = frame_done_r;
    assign o_frame_error = frame_error_r;
    assign o_busy        = ~cs_sync_r;

endmodule

// File: tb/tb_spi_slave_model.sv
// Self-checking bench for spi_slave_model: a behavioural SPI master drives random frames
// and a table/word-level reference model predicts MISO words, received words and flags.
module tb_spi_slave_model;
    localparam int H = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        sck32, cs32, mosi32, ld32_v;
    logic [1:0]  ld32_a;
    logic [31:0] ld32_d;
    wire         miso32;
    wire  [31:0] rxd32;
    wire         rxv32, fd32, fe32, busy32;
    wire  [1:0]  widx32;
    pullup pu_miso (miso32);

    spi_slave_model #(.DATA_WIDTH(32), .WORDS(4), .CPOL(1'b0), .CPHA(1'b0),
                      .MSB_FIRST(1'b1), .INIT_WORD(32'hACDC1112)) u_dut (
        .i_system_clk(clk), .i_reset_n(rst_n), .i_sck(sck32), .i_cs(cs32), .i_mosi(mosi32),
        .o_miso(miso32), .i_load_valid(ld32_v), .i_load_addr(ld32_a), .i_load_data(ld32_d),
        .o_rx_data(rxd32), .o_rx_valid(rxv32), .o_word_index(widx32), .o_frame_done(fd32),
        .o_frame_error(fe32), .o_busy(busy32));

    // 8-bit instances: g0 mode1, g1 mode2, g2 mode3 (MSB first), g3 mode0 LSB first
    logic [3:0] sck8, cs8;
    logic       mosi8, ld8_v;
    logic [1:0] ld8_a;
    logic [7:0] ld8_d;
    wire  [3:0] miso8, rxv8, fd8, fe8, busy8;
    wire  [7:0] rxd8 [4];
    wire  [1:0] widx8 [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut8
        spi_slave_model #(.DATA_WIDTH(8), .WORDS(4), .CPOL(g == 1 || g == 2),
                          .CPHA(g == 0 || g == 2), .MSB_FIRST(g != 3)) u_dut8 (
            .i_system_clk(clk), .i_reset_n(rst_n), .i_sck(sck8[g]), .i_cs(cs8[g]),
            .i_mosi(mosi8), .o_miso(miso8[g]), .i_load_valid(ld8_v), .i_load_addr(ld8_a),
            .i_load_data(ld8_d), .o_rx_data(rxd8[g]), .o_rx_valid(rxv8[g]),
            .o_word_index(widx8[g]), .o_frame_done(fd8[g]), .o_frame_error(fe8[g]),
            .o_busy(busy8[g]));
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] rxq [$];
    int          fd_cnt = 0;
    int          rxv8_cnt [4] = '{default: 0};
    int          fd8_cnt [4]  = '{default: 0};

    always @(negedge clk) begin
        if (rxv32) rxq.push_back(rxd32);
        if (fd32) fd_cnt++;
        for (int g = 0; g < 4; g++) begin
            if (rxv8[g]) rxv8_cnt[g]++;
            if (fd8[g]) fd8_cnt[g]++;
        end
    end

    logic [31:0] model_tab [4];
    logic [31:0] tx_w [8];
    logic [31:0] miso_w [8];
    logic [1:0]  idx_seen [8];

    task automatic tab32_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        ld32_v = 1'b1; ld32_a = a; ld32_d = d;
        @(negedge clk);
        ld32_v = 1'b0;
        model_tab[a] = d;
    endtask

    // Mode-0 MSB-first master; optional table write two cycles after trailing edge wr_bit
    task automatic xfer32(input int nbits, input int wr_bit, input logic [1:0] wa,
                          input logic [31:0] wd);
        int w, b;
        cs32 = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("err_clr", 64'(fe32), 64'd0);
        check_eq("busy", 64'(busy32), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            w = i / 32;
            b = 31 - (i % 32);
            mosi32 = tx_w[w][b];
            for (int j = 0; j < H; j++) begin
                @(negedge clk);
                ld32_v = (wr_bit >= 0 && i == wr_bit + 1 && j == 1);
                ld32_a = wa;
                ld32_d = wd;
            end
            miso_w[w][b] = miso32;
            if (i % 32 == 16) idx_seen[w] = widx32;
            sck32 = 1'b1;
            repeat (H) @(negedge clk);
            sck32 = 1'b0;
        end
        repeat (H) @(negedge clk);
        ld32_v = 1'b0;
        cs32 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run32(input int nfull, input int extra, input int wr_bit,
                         input logic [1:0] wa, input logic [31:0] wd, input bit rand_tx);
        int          fd0;
        logic [31:0] exp_w;
        if (rand_tx) for (int w = 0; w < 8; w++) tx_w[w] = $urandom();
        rxq.delete();
        fd0 = fd_cnt;
        xfer32(32 * nfull + extra, wr_bit, wa, wd);
        for (int w = 0; w < nfull; w++) begin
            exp_w = model_tab[w % 4];
            if (wr_bit >= 0 && w > 0 && wa == 2'(w % 4) && 32 * w - 1 > wr_bit) exp_w = wd;
            check_eq($sformatf("miso_word%0d", w), 64'(miso_w[w]), 64'(exp_w));
            check_eq($sformatf("word_idx%0d", w), 64'(idx_seen[w]), 64'(w % 4));
        end
        check_eq("rx_count", 64'(rxq.size()), 64'(nfull));
        for (int w = 0; w < nfull && w < rxq.size(); w++)
            check_eq($sformatf("rx_word%0d", w), 64'(rxq[w]), 64'(tx_w[w]));
        check_eq("frame_done", 64'(fd_cnt - fd0), 64'd1);
        check_eq("frame_error", 64'(fe32), 64'(extra != 0));
        check_eq("idx_idle", 64'(widx32), 64'd0);
        if (wr_bit >= 0) model_tab[wa] = wd;
    endtask

    task automatic tab8_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld8_v = 1'b1; ld8_a = a; ld8_d = d;
        @(negedge clk);
        ld8_v = 1'b0;
    endtask

    // Generic one-word master for the 8-bit instances in their own mode and bit order
    task automatic xfer8(input int g, input logic [7:0] mw, output logic [7:0] sw);
        bit cp, ph, msb;
        int pos;
        cp  = (g == 1 || g == 2);
        ph  = (g == 0 || g == 2);
        msb = (g != 3);
        sw  = 8'h00;
        cs8[g] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            pos = msb ? 7 - i : i;
            if (!ph) mosi8 = mw[pos];
            repeat (H) @(negedge clk);
            if (!ph) sw[pos] = miso8[g];
            sck8[g] = ~cp;
            if (ph) mosi8 = mw[pos];
            repeat (H) @(negedge clk);
            if (ph) sw[pos] = miso8[g];
            sck8[g] = cp;
        end
        repeat (H) @(negedge clk);
        cs8[g] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run8(input int g, input logic [7:0] tab0, input logic [7:0] mw);
        int         c0, f0;
        logic [7:0] sw;
        tab8_write(2'd0, tab0);
        c0 = rxv8_cnt[g];
        f0 = fd8_cnt[g];
        xfer8(g, mw, sw);
        check_eq($sformatf("miso8_g%0d", g), 64'(sw), 64'(tab0));
        check_eq($sformatf("rx8_g%0d", g), 64'(rxd8[g]), 64'(mw));
        check_eq($sformatf("rxv8_g%0d", g), 64'(rxv8_cnt[g] - c0), 64'd1);
        check_eq($sformatf("fd8_g%0d", g), 64'(fd8_cnt[g] - f0), 64'd1);
        check_eq($sformatf("fe8_g%0d", g), 64'(fe8[g]), 64'd0);
        check_eq($sformatf("idx8_g%0d", g), 64'(widx8[g]), 64'd0);
        check_eq($sformatf("busy8_g%0d", g), 64'(busy8[g]), 64'd0);
    endtask

    initial begin
        int fd0, nfull, extra, wr_bit, nbits;
        rst_n = 1'b0;
        sck32 = 1'b0; cs32 = 1'b1; mosi32 = 1'b0;
        ld32_v = 1'b0; ld32_a = 2'd0; ld32_d = 32'h0;
        sck8 = 4'b0110; cs8 = 4'hF; mosi8 = 1'b0;
        ld8_v = 1'b0; ld8_a = 2'd0; ld8_d = 8'h00;
        for (int i = 0; i < 4; i++) model_tab[i] = 32'hACDC1112;
        repeat (3) @(negedge clk);
        check_eq("rst_rx_data", 64'(rxd32), 64'd0);
        check_eq("rst_rx_valid", 64'(rxv32), 64'd0);
        check_eq("rst_word_idx", 64'(widx32), 64'd0);
        check_eq("rst_frame_done", 64'(fd32), 64'd0);
        check_eq("rst_frame_error", 64'(fe32), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("idle_busy", 64'(busy32), 64'd0);
        check_eq("idle_miso_z", 64'(miso32), 64'd1);

        tx_w[0] = 32'h12345678;
        run32(1, 0, -1, 2'd0, 32'h0, 1'b0);

        tab32_write(2'd0, 32'h11111111);
        tab32_write(2'd1, 32'h22222222);
        tab32_write(2'd2, 32'h33333333);
        tab32_write(2'd3, 32'h44444444);
        run32(5, 0, -1, 2'd0, 32'h0, 1'b1);

        run32(0, 13, -1, 2'd0, 32'h0, 1'b1);
        run32(1, 0, -1, 2'd0, 32'h0, 1'b1);

        run32(2, 0, 4, 2'd1, 32'hDEADBEEF, 1'b1);
        run32(2, 0, 31, 2'd1, 32'hCAFEF00D, 1'b1);
        run32(2, 0, -1, 2'd0, 32'h0, 1'b1);

        for (int g = 0; g < 4; g++) begin
            run8(g, 8'hA5, 8'h3C);
            for (int r = 0; r < 2; r++) run8(g, 8'($urandom()), 8'($urandom()));
        end

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) tab32_write(2'($urandom()), $urandom());
            extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 0;
            nfull = int'($urandom_range(1, 5));
            nbits = 32 * nfull + extra;
            wr_bit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nbits - 2)) : -1;
            run32(nfull, extra, wr_bit, 2'($urandom()), $urandom(), 1'b1);
        end

        tx_w[0] = 32'h5A5A0F0F;
        tx_w[1] = $urandom();
        fd0 = fd_cnt;
        cs32 = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            mosi32 = tx_w[i / 32][31 - (i % 32)];
            repeat (H) @(negedge clk);
            sck32 = 1'b1;
            repeat (H) @(negedge clk);
            sck32 = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_eq("pre_rst_rx", 64'(rxd32), 64'h5A5A0F0F);
        check_eq("pre_rst_idx", 64'(widx32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_rx_data", 64'(rxd32), 64'd0);
        check_eq("arst_word_idx", 64'(widx32), 64'd0);
        check_eq("arst_rx_valid", 64'(rxv32), 64'd0);
        check_eq("arst_busy", 64'(busy32), 64'd0);
        check_eq("arst_error", 64'(fe32), 64'd0);
        cs32 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("post_rst_miso_z", 64'(miso32), 64'd1);
        check_eq("post_rst_no_done", 64'(fd_cnt - fd0), 64'd0);
        for (int i = 0; i < 4; i++) model_tab[i] = 32'hACDC1112;
        run32(2, 0, -1, 2'd0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_slave_model.md
Name: spi_slave_model

Overview:
- Parametrised, synthesizable SPI slave device model for benches and loopback test of the SPI master.
- Samples an asynchronous SPI bus (SCK/CS/MOSI) in the system clock domain.
- Shifts out words from a programmable response table on MISO and captures MOSI words into a receive register.
- Supports all four CPOL/CPHA modes, bit order select, and multi-word frames with table wrap.

Parameters:
DATA_WIDTH, 32, bits per SPI word (8..64)
WORDS, 4, response table depth (power of 2, >=2)
CPOL, 0, idle level of SCK
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
INIT_WORD, 32'hACDC1112, reset value of every table entry (truncated/zero-extended to DATA_WIDTH)

Ports:
i_system_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_sck  in  1  SPI clock, asynchronous
i_cs  in  1  chip select, active low, asynchronous
i_mosi  in  1  master-out data, asynchronous
o_miso  out  1  slave-out data; high-Z whenever i_cs==1
i_load_valid  in  1  table write strobe
i_load_addr  in  $clog2(WORDS)  table write address
i_load_data  in  DATA_WIDTH  table write data
o_rx_data  out  DATA_WIDTH  last complete received word
o_rx_valid  out  1  one-cycle pulse on o_rx_data update
o_word_index  out  $clog2(WORDS)  table index of the word being transmitted
o_frame_done  out  1  one-cycle pulse on CS deassertion
o_frame_error  out  1  sticky until next CS fall: frame ended with partial word
o_busy  out  1  synchronised CS asserted

Behaviour:
- Reset (async assert, sync release): table = INIT_WORD, shift regs 0, bit count 0, o_word_index 0, o_rx_data 0, all pulses/flags 0, internal MISO 0.
- i_sck, i_cs, i_mosi pass through 2-flop synchronisers plus one history flop; edges are detected on synchronised values. The raw i_cs gates the o_miso tristate combinationally.
- Constraint: each SCK half-period >= 4 system clocks. Faster SCK is unsupported and undefined.
- Edge definition:
  - Leading edge = idle->active transition of SCK relative to CPOL; trailing edge = return to idle.
  - CPHA=0: sample MOSI on leading edge, shift TX on trailing edge.
  - CPHA=1: shift TX on leading edge, sample on trailing edge.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synchronised CS fall:
  - Load TX shift reg with table[0]; bit count 0; word index 0; clear o_frame_error.
  - MISO presents first bit the cycle after detection.
  - CPHA=1: the first leading edge performs no shift; it only arms the sampling.
- ACTIVE: each sample edge shifts the MOSI bit into the RX shift reg, in MSB_FIRST order, and increments bit count.
- When bit count reaches DATA_WIDTH:
  - o_rx_data <= assembled word; o_rx_valid pulses 1 cycle; bit count <= 0.
  - Word index increments mod WORDS (wraps WORDS-1 -> 0).
  - The next shift edge loads table[new index] instead of shifting.
- ACTIVE -> IDLE on synchronised CS rise:
  - o_frame_done pulses.
  - If bit count != 0: partial RX word discarded (no o_rx_valid) and o_frame_error set.
  - Word index and bit count return to 0.
- Table writes are accepted in any state, one per cycle. A table load reads the pre-write value if the write lands in the same cycle to the same address; the write affects only later loads.
- SCK edges while CS is deasserted are ignored. A CS fall coinciding with an SCK edge in the same synchronised cycle: CS handling takes priority and the edge is ignored.
- Reset mid-frame: immediate return to IDLE with reset values; no o_frame_done pulse.

Test Plan:
- Mode 0, MSB_FIRST, 32 SCK clocks, MOSI=0x12345678 -> MISO stream 0xACDC1112, o_rx_data=0x12345678 with one o_rx_valid pulse, o_frame_done on CS rise, o_frame_error=0.
- Modes 1, 2, 3 and MSB_FIRST=0 with DATA_WIDTH=8, table[0]=0xA5, MOSI=0x3C -> MISO bits match mode timing, o_rx_data=0x3C each mode.
- Table = {0x11111111,0x22222222,0x33333333,0x44444444}, 5-word frame -> MISO words 0x11..,0x22..,0x33..,0x44..,0x11.. (wrap); 5 o_rx_valid pulses; o_word_index 0,1,2,3,0.
- CS deasserted after 13 bits -> no o_rx_valid, o_frame_error=1, o_frame_done pulse; next frame restarts at table[0] bit 0 and clears error.
- Write table[1]=0xDEADBEEF during word 0 of a frame -> word 1 on MISO is 0xDEADBEEF; a write coinciding with the load of word 1 -> old value is sent.
- i_reset_n asserted mid-word -> all outputs at reset values asynchronously, table back to INIT_WORD; o_miso high-Z once CS rises.
